mem_copy_engine: RTL
====================

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, meaning number of words in the attached data memory; all addresses wrap modulo MEM_DEPTH.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a transfer; sampled only in IDLE.
REQ-005 SHALL have port mode  input  1  0 = copy (read src, write dst), 1 = fill (write fill_value to dst).
REQ-006 SHALL have port src_addr  input  8  first source address, copy mode.
REQ-007 SHALL have port dst_addr  input  8  first destination address.
REQ-008 SHALL have port length  input  7  number of bytes, 0..127.
REQ-009 SHALL have port fill_value  input  8  byte written in fill mode.
REQ-010 SHALL have port abort  input  1  cancel an in-progress transfer.
REQ-011 SHALL have port mem_address  output  8  memory address.
REQ-012 SHALL have port mem_write_data  output  8  memory write data.
REQ-013 SHALL have port mem_memread  output  1  memory read enable; memory returns data combinationally.
REQ-014 SHALL have port mem_memwrite  output  1  memory write enable; memory writes on the rising edge.
REQ-015 SHALL have port mem_read_data  input  8  data returned by memory.
REQ-016 SHALL have port busy  output  1  high in READ and WRITE states.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, DONE; memory outputs are registered and decoded from state.
REQ-019 In IDLE, start=1 at an edge SHALL latch src_addr mod MEM_DEPTH, dst_addr mod MEM_DEPTH, mode, fill_value, and length clamped to MEM_DEPTH; start is ignored in all other states.
REQ-020 Transition from IDLE on start SHALL go to DONE if latched length = 0; else to READ (copy) or WRITE (fill).
REQ-021 In READ: mem_memread=1, mem_address=current src, mem_memwrite=0; at the edge mem_read_data SHALL be captured into the data register; next state WRITE.
REQ-022 In WRITE: mem_memwrite=1, mem_memread=0, mem_address=current dst, mem_write_data=captured byte (copy) or fill_value (fill).
REQ-023 At each WRITE edge: src and dst SHALL each increment by 1 mod MEM_DEPTH, remaining count decrements; if remaining becomes 0 next state is DONE, else READ (copy) or WRITE (fill).
REQ-024 Copy SHALL proceed in ascending address order, one byte per 2 cycles; overlapping ranges SHALL produce exactly the result of this byte-by-byte ascending order.
REQ-025 Fill SHALL write one byte per cycle.
REQ-026 DONE SHALL last exactly one cycle with done=1, busy=0, memory enables 0, then go to IDLE.
REQ-027 With start sampled at edge 0, copy of L>0 bytes SHALL assert done in cycle 2L+1; fill in cycle L+1; L=0 in cycle 1.
REQ-028 abort=1 at an edge in READ or WRITE SHALL go to DONE; a WRITE cycle coinciding with abort still completes its write; abort in IDLE/DONE has no effect.
REQ-029 Outside READ/WRITE, mem_address and mem_write_data SHALL be 0 and both enables 0.
REQ-030 mem_memread and mem_memwrite SHALL never be high in the same cycle.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE, clear busy, done, both enables, mem_address, mem_write_data, counters, and data register to 0, overriding start and abort.
REQ-032 Reset mid-transfer SHALL issue no further writes; bytes already written remain.

Verification
REQ-033 Memory preloaded mem[i]=i; copy src=4 dst=40 len=3 -> mem[40..42]=4,5,6; done in cycle 7; busy high cycles 1-6.
REQ-034 Fill dst=10 len=4 fill=8'hAA -> mem[10..13]=AA, one write per cycle, done in cycle 5.
REQ-035 Copy src=62 dst=0 len=4 -> reads 62,63,0,1; mem[0..3]=62,63,62,63 (ascending overlap rule); addresses never exceed 63.
REQ-036 len=0 -> done in cycle 1, no enable ever asserted; start pulsed while busy -> ignored, transfer unchanged.
REQ-037 Copy len=10 with abort at cycle 4 (WRITE) -> exactly 2 bytes written, done cycle 5; rst at cycle 3 of another copy -> 1 byte written, all outputs 0 next cycle, no done pulse.

Source files
------------

// File: rtl/mem_copy_engine.sv
// Byte copy / fill engine driving a single-port data memory.
// Copy alternates READ and WRITE per byte; fill issues one WRITE per cycle.
module mem_copy_engine #(
   parameter int unsigned MEM_DEPTH = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic [7:0] src_addr,
   input  logic [7:0] dst_addr,
   input  logic [6:0] length,
   input  logic [7:0] fill_value,
   input  logic       abort,
   output logic [7:0] mem_address,
   output logic [7:0] mem_write_data,
   output logic       mem_memread,
   output logic       mem_memwrite,
   input  logic [7:0] mem_read_data,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] src_q, src_d;
   logic [7:0] dst_q, dst_d;
   logic [6:0] cnt_q, cnt_d;
   logic       mode_q, mode_d;
   logic [7:0] fill_q, fill_d;
   logic [7:0] data_q, data_d;
   logic [7:0] maddr_q, maddr_d;
   logic [7:0] mwdata_q, mwdata_d;
   logic       mrd_q, mrd_d;
   logic       mwr_q, mwr_d;
   logic [6:0] len_clamped;

   function automatic logic [7:0] wrap_inc(input logic [7:0] a);
      if (32'(a) >= MEM_DEPTH - 1)
         return '0;
      return a + 8'd1;
   endfunction

   always_comb begin
      len_clamped = length;
      if (32'(length) > MEM_DEPTH)
         len_clamped = 7'(MEM_DEPTH);
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      fill_d  = fill_q;
      data_d  = data_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d  = 8'(32'(src_addr) % MEM_DEPTH);
               dst_d  = 8'(32'(dst_addr) % MEM_DEPTH);
               cnt_d  = len_clamped;
               mode_d = mode;
               fill_d = fill_value;
               if (len_clamped == '0)
                  state_d = S_DONE;
               else if (mode)
                  state_d = S_WRITE;
               else
                  state_d = S_READ;
            end
         end
         S_READ: begin
            data_d  = mem_read_data;
            state_d = abort ? S_DONE : S_WRITE;
         end
         S_WRITE: begin
            src_d = wrap_inc(src_q);
            dst_d = wrap_inc(dst_q);
            cnt_d = cnt_q - 7'd1;
            if (abort || cnt_q == 7'd1)
               state_d = S_DONE;
            else if (mode_q)
               state_d = S_WRITE;
            else
               state_d = S_READ;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Memory strobes are registered from the next state so they line up with it.
   always_comb begin
      mrd_d    = (state_d == S_READ);
      mwr_d    = (state_d == S_WRITE);
      maddr_d  = '0;
      mwdata_d = '0;
      if (state_d == S_READ)
         maddr_d = src_d;
      if (state_d == S_WRITE) begin
         maddr_d  = dst_d;
         mwdata_d = mode_d ? fill_d : data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         fill_q   <= '0;
         data_q   <= '0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         mrd_q    <= 1'b0;
         mwr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         cnt_q    <= cnt_d;
         mode_q   <= mode_d;
         fill_q   <= fill_d;
         data_q   <= data_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
         mrd_q    <= mrd_d;
         mwr_q    <= mwr_d;
      end
   end

   assign mem_address    = maddr_q;
   assign mem_write_data = mwdata_q;
   assign mem_memread    = mrd_q;
   assign mem_memwrite   = mwr_q;
   assign busy           = (state_q == S_READ) || (state_q == S_WRITE);
   assign done           = (state_q == S_DONE);

endmodule
